// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the multi-port instruction FIFO.
// Pointer and count arithmetic is done in 32 bits and narrowed by the caller.
package fifo_pkg;

    localparam int FIFO_WIDTH = 64;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_PORTS = 2;

    // Number of set bits in a (thermometer-coded) lane mask.
    function automatic logic [31:0] therm_popcount(input logic [31:0] v);
        logic [31:0] n;
        n = 32'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    // Caller narrows the sum to the pointer width; DEPTH is a power of 2, so this wraps modulo DEPTH.
    function automatic logic [31:0] ptr_add(input logic [31:0] ptr, input logic [31:0] inc);
        return ptr + inc;
    endfunction

    // True when v is of the form 0...01...1 (including zero).
    function automatic logic is_therm(input logic [31:0] v);
        return ((v & (v + 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/fifo_mem_mp.sv
// Register-array storage with WR_PORTS write ports and RD_PORTS combinational read ports.
// Storage is deliberately not reset.
module fifo_mem_mp
    import fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_WIDTH,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int WR_PORTS = FIFO_PORTS,
    parameter int RD_PORTS = FIFO_PORTS
) (
    input  logic                               clk,
    input  logic [WR_PORTS-1:0]                wr_en,
    input  logic [WR_PORTS*$clog2(DEPTH)-1:0]  wr_addr,
    input  logic [WR_PORTS*WIDTH-1:0]          wr_data,
    input  logic [RD_PORTS*$clog2(DEPTH)-1:0]  rd_addr,
    output logic [RD_PORTS*WIDTH-1:0]          rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write lanes always target distinct consecutive addresses, so no two ports collide.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WR_PORTS; k++) begin
            if (wr_en[k]) begin
                mem_r[wr_addr[k*AW +: AW]] <= wr_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Show-ahead read ports.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < RD_PORTS; k++) begin
            rd_data[k*WIDTH +: WIDTH] = mem_r[rd_addr[k*AW +: AW]];
        end
    end

endmodule

// File: rtl/multiport_fifo.sv
// N-wide in-order fetch-to-decode queue: pointers, occupancy, handshakes, stall and flush.
// Optional sticky overflow flag and encoding checks: define MULTIPORT_FIFO_OVERFLOW_CHK_EN.
module multiport_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_WIDTH,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int WR_PORTS = FIFO_PORTS,
    parameter int RD_PORTS = FIFO_PORTS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WR_PORTS-1:0]         wr_en,
    input  logic [WR_PORTS*WIDTH-1:0]   wr_data,
    output logic                        wr_ready,
    output logic [RD_PORTS*WIDTH-1:0]   rd_data,
    output logic [RD_PORTS-1:0]         rd_valid,
    input  logic [RD_PORTS-1:0]         rd_en,
    input  logic                        stall,
    input  logic                        flush,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty
`ifdef MULTIPORT_FIFO_OVERFLOW_CHK_EN
    ,
    output logic                        overflow_err
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]          head_r, tail_r;
    logic [CNT_W-1:0]          count_r;
    logic [RD_PORTS-1:0]       rd_valid_r;
    logic                      full_r, empty_r, wr_ready_r;

    logic [CNT_W-1:0]          nwr_s, npop_s, count_next_s;
    logic [PTR_W-1:0]          head_next_s, tail_next_s;
    logic [RD_PORTS-1:0]       rd_valid_next_s;
    logic [WR_PORTS-1:0]       wr_lane_en_s;
    logic [WR_PORTS*PTR_W-1:0] wr_addr_s;
    logic [RD_PORTS*PTR_W-1:0] rd_addr_s;

    fifo_mem_mp #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .WR_PORTS (WR_PORTS),
        .RD_PORTS (RD_PORTS)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_lane_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data)
    );

    // Accept/pop counts, lane addresses and next pointer/occupancy state; flush wins over both sides.
    always_comb begin
        nwr_s           = '0;
        npop_s          = '0;
        wr_lane_en_s    = '0;
        wr_addr_s       = '0;
        rd_addr_s       = '0;
        count_next_s    = count_r;
        head_next_s     = head_r;
        tail_next_s     = tail_r;
        rd_valid_next_s = '0;

        if (wr_ready_r && !flush) begin
            nwr_s = CNT_W'(therm_popcount(32'(wr_en)));
        end else begin
            nwr_s = '0;
        end

        if (!stall && !flush) begin
            npop_s = CNT_W'(therm_popcount(32'(rd_en & rd_valid_r)));
        end else begin
            npop_s = '0;
        end

        for (int k = 0; k < WR_PORTS; k++) begin
            wr_lane_en_s[k]                 = (32'(k) < 32'(nwr_s));
            wr_addr_s[k*PTR_W +: PTR_W]     = PTR_W'(ptr_add(32'(tail_r), 32'(k)));
        end
        for (int k = 0; k < RD_PORTS; k++) begin
            rd_addr_s[k*PTR_W +: PTR_W]     = PTR_W'(ptr_add(32'(head_r), 32'(k)));
        end

        if (flush) begin
            count_next_s = '0;
            head_next_s  = '0;
            tail_next_s  = '0;
        end else begin
            count_next_s = count_r + nwr_s - npop_s;
            head_next_s  = PTR_W'(ptr_add(32'(head_r), 32'(npop_s)));
            tail_next_s  = PTR_W'(ptr_add(32'(tail_r), 32'(nwr_s)));
        end

        for (int k = 0; k < RD_PORTS; k++) begin
            rd_valid_next_s[k] = (32'(count_next_s) > 32'(k));
        end
    end

    // Pointer/count state plus status flags registered from the next occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
            rd_valid_r <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            wr_ready_r <= 1'b1;
        end else begin
            head_r     <= head_next_s;
            tail_r     <= tail_next_s;
            count_r    <= count_next_s;
            rd_valid_r <= rd_valid_next_s;
            full_r     <= (32'(count_next_s) == DEPTH);
            empty_r    <= (count_next_s == '0);
            wr_ready_r <= ((32'(count_next_s) + 32'(WR_PORTS)) <= DEPTH);
        end
    end

    assign count    = count_r;
    assign full     = full_r;
    assign empty    = empty_r;
    assign wr_ready = wr_ready_r;
    assign rd_valid = rd_valid_r;

`ifdef MULTIPORT_FIFO_OVERFLOW_CHK_EN
    logic overflow_r;

    // Sticky flag for writes offered while the queue could not take a full group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (flush) begin
            overflow_r <= 1'b0;
        end else if ((|wr_en) && !wr_ready_r) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign overflow_err = overflow_r;

    multiport_fifo_chk #(
        .WR_PORTS (WR_PORTS),
        .RD_PORTS (RD_PORTS)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .rd_en (rd_en)
    );
`endif

endmodule

`ifdef MULTIPORT_FIFO_OVERFLOW_CHK_EN
// Lane request masks must be thermometer coded (lane 0 oldest).
module multiport_fifo_chk
    import fifo_pkg::*;
#(
    parameter int WR_PORTS = FIFO_PORTS,
    parameter int RD_PORTS = FIFO_PORTS
) (
    input logic                clk,
    input logic                rst,
    input logic [WR_PORTS-1:0] wr_en,
    input logic [RD_PORTS-1:0] rd_en
);

    a_wr_therm: assert property (@(posedge clk) disable iff (rst) is_therm(32'(wr_en)));
    a_rd_therm: assert property (@(posedge clk) disable iff (rst) is_therm(32'(rd_en)));

endmodule
`endif

// File: doc/multiport_fifo.md
Name: multiport_fifo

Overview:
- Parametrised successor to the single-lane instruction FIFO.
- N-wide in-order queue between fetch and decode in the superscalar front end.
- Accepts up to WR_PORTS entries per cycle and presents the oldest RD_PORTS entries show-ahead.
- Adds per-lane valid/consume handshakes, occupancy count, stall and flush.

Parameters:
- WIDTH, 64, bits per entry ({pc, instr}).
- DEPTH, 8, number of entries; power of 2, at least max(WR_PORTS, RD_PORTS).
- WR_PORTS, 2, entries writable per cycle.
- RD_PORTS, 2, entries readable/poppable per cycle.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- wr_en  in  WR_PORTS  thermometer write request; lane 0 is oldest; bit k set implies bits below k set.
- wr_data  in  WR_PORTS*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- wr_ready  out  1  queue can take a full WR_PORTS group this cycle.
- rd_data  out  RD_PORTS*WIDTH  lane k = k-th oldest entry (show-ahead, combinational from storage).
- rd_valid  out  RD_PORTS  bit k = (count > k).
- rd_en  in  RD_PORTS  thermometer pop request, honoured only where rd_valid.
- stall  in  1  freezes the read side.
- flush  in  1  synchronous discard of all contents.
- count  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (async, active-high):
  - head = tail = 0, count = 0.
  - Resulting outputs: empty=1, full=0, rd_valid=0, wr_ready=1.
  - rd_data is don't-care; the bench compares only under rd_valid.
  - Storage is not reset.
- State: head/tail pointers, $clog2(DEPTH) bits each, wrapping modulo DEPTH; count register. No FSM beyond pointer/count state.
- wr_ready = (DEPTH - count) >= WR_PORTS, using registered count. Pops in the same cycle are not credited (no fall-through).
- Write acceptance:
  - A write is accepted only when wr_ready=1.
  - Accepted writes store popcount(wr_en) entries: lane k at (tail+k) mod DEPTH, and tail advances by popcount(wr_en).
  - wr_en while wr_ready=0 is dropped silently and must be held by the producer.
  - Non-thermometer wr_en is illegal; behaviour is undefined (an assertion fires in simulation).
- Pops:
  - npop = popcount(rd_en & rd_valid) when stall=0, else 0.
  - head advances by npop; popped lanes are the lowest ones.
- count_next = count + nwr - npop. Simultaneous write and pop is legal at any occupancy, including empty (no pop possible) and full (no write possible).
- Latency: a written entry is visible on rd_data/rd_valid the cycle after acceptance. Empty-to-valid takes 1 cycle.
- Stall:
  - Blocks pops only; writes continue while wr_ready=1.
  - rd_data/rd_valid are stable unless new entries arrive behind the existing ones.
- Flush:
  - head=tail=0, count=0 next cycle.
  - Overrides same-cycle writes and pops; those writes are discarded.
- Wrap-around: multi-entry writes and reads that straddle index DEPTH-1 to 0 must be contiguous in order.

Optional Feature:
- Macro: MULTIPORT_FIFO_OVERFLOW_CHK_EN.
- When defined:
  - Adds output `overflow_err` (1 bit, sticky).
  - Sets when wr_en != 0 while wr_ready=0 and flush=0.
  - Cleared only by rst or flush.
  - Also enables the thermometer-encoding assertions on wr_en and rd_en.
- When undefined: the port and the checks are absent, and dropped writes are silent.

Decomposition:
- Package fifo_pkg:
  - Default localparams: FIFO_WIDTH=64, FIFO_DEPTH=8, FIFO_PORTS=2.
  - Function `therm_popcount`.
  - Function `ptr_add(ptr, inc)` for modulo wrap.
- One sub-module, fifo_mem_mp:
  - Register array with WR_PORTS write ports and RD_PORTS combinational read ports, indexed by wrapped addresses.
  - multiport_fifo holds the pointers, count, handshake and flush logic.

Test Plan (defaults WIDTH=64, DEPTH=8, 2/2 ports):
- Reset, then write wr_en=2'b11 with data 10,20 → next cycle rd_valid=2'b11, rd_data lanes = 10,20, count=2.
- Fill to 8 with 4 double writes (values 1..8) → full=1 and wr_ready=0 at count=7 too. A wr_en=2'b01 at count=7 is dropped; overflow_err=1 if the macro is defined.
- With count=8, pop rd_en=2'b11 and write 2'b11 in the same cycle (write rejected, wr_ready=0) → count=6, lanes show 3,4.
- Raise stall with count=4 and rd_en=2'b11 for 3 cycles while writing 2'b11 once → count=6, rd_data unchanged. Drop stall → pops 2 per cycle in order.
- Wrap: push/pop pairs for 20 cycles with an incrementing pattern → FIFO order preserved across the index 7→0 boundary, no lost or duplicated entry.
- flush with count=5 plus a simultaneous 2'b11 write → next cycle count=0, empty=1. Reset asserted mid-write → immediate empty=1 without waiting for a clock edge.
